// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the inter-stage pipeline registers: update-kind codes,
// the default NOP control word, and control-field bit positions.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_LOADED  = 2'd0;
    localparam logic [1:0] ST_HELD    = 2'd1;
    localparam logic [1:0] ST_FLUSHED = 2'd2;

    localparam logic [15:0] NOP_CTRL_DEFAULT = 16'h0000;
    localparam logic [4:0]  RD_ZERO          = 5'd0;

    localparam int CTRL_BIT_REG_WRITE = 0;
    localparam int CTRL_BIT_MEM_READ  = 1;
    localparam int CTRL_BIT_MEM_WRITE = 2;
    localparam int CTRL_BIT_BRANCH    = 3;
    localparam int CTRL_BIT_JAL       = 4;
    localparam int CTRL_BIT_JALR      = 5;

    // Stall outranks bubble; with neither, the stage loads.
    function automatic logic [1:0] upd_kind(input logic stall, input logic bubble);
        logic [1:0] kind;
        if (stall) begin
            kind = ST_HELD;
        end else if (bubble) begin
            kind = ST_FLUSHED;
        end else begin
            kind = ST_LOADED;
        end
        return kind;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter with synchronous reset, synchronous clear and saturation at
// all-ones; clear wins over a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic             w_step;

    // Increment only while below the ceiling so the count never wraps.
    always_comb begin
        if (i_inc && (r_cnt != CNT_MAX)) begin
            w_step = 1'b1;
        end else begin
            w_step = 1'b0;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_step) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register honouring the hazard unit's stall/bubble pair,
// with stall/bubble activity counters and a sticky stuck-stall watchdog.
module pipe_stage_reg
    import pipe_ctrl_pkg::*;
#(
    parameter int                DATA_W        = 64,
    parameter int                CTRL_W        = 16,
    parameter logic [CTRL_W-1:0] NOP_CTRL      = CTRL_W'(NOP_CTRL_DEFAULT),
    parameter int                CNT_W         = 16,
    parameter int                STALL_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              clr_cnt,
    input  logic              in_valid,
    input  logic [4:0]        in_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_state,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              stall_timeout
);

    // The run counter holds the stalls seen before this edge, so the trip
    // edge is the one where it already equals STALL_TIMEOUT-1.
    localparam logic [CNT_W-1:0] TRIP_AT = CNT_W'(STALL_TIMEOUT - 1);

    logic              r_valid;
    logic [4:0]        r_rd;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data;
    logic [1:0]        r_state;
    logic              r_timeout;

    logic              w_bubble_eff;
    logic              w_run_clr;
    logic              w_trip;
    logic [CNT_W-1:0]  w_run_cnt;

    // Qualify bubble against stall and derive watchdog controls.
    always_comb begin
        w_bubble_eff = bubble & ~stall;
        w_run_clr    = ~stall | clr_cnt;
        if (stall && (w_run_cnt == TRIP_AT)) begin
            w_trip = 1'b1;
        end else begin
            w_trip = 1'b0;
        end
    end

    // Payload register: reset > stall > bubble > load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_rd    <= RD_ZERO;
            r_ctrl  <= NOP_CTRL;
            r_data  <= {DATA_W{1'b0}};
            r_state <= ST_FLUSHED;
        end else if (stall) begin
            r_state <= upd_kind(stall, bubble);
        end else if (bubble) begin
            r_valid <= 1'b0;
            r_rd    <= RD_ZERO;
            r_ctrl  <= NOP_CTRL;
            r_data  <= {DATA_W{1'b0}};
            r_state <= upd_kind(stall, bubble);
        end else begin
            r_valid <= in_valid;
            r_rd    <= in_valid ? in_rd : RD_ZERO;
            r_ctrl  <= in_valid ? in_ctrl : NOP_CTRL;
            r_data  <= in_data;
            r_state <= upd_kind(stall, bubble);
        end
    end

    // Sticky watchdog flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout <= 1'b0;
        end else if (clr_cnt) begin
            r_timeout <= 1'b0;
        end else if (w_trip) begin
            r_timeout <= 1'b1;
        end else begin
            r_timeout <= r_timeout;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (clr_cnt),
        .i_inc (stall),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (clr_cnt),
        .i_inc (w_bubble_eff),
        .o_cnt (bubble_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_run_cnt (
        .i_clk (clk),
        .i_rst (rst),
        .i_clr (w_run_clr),
        .i_inc (stall),
        .o_cnt (w_run_cnt)
    );

    assign out_valid     = r_valid;
    assign out_rd        = r_rd;
    assign out_ctrl      = r_ctrl;
    assign out_data      = r_data;
    assign out_state     = r_state;
    assign stall_timeout = r_timeout;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB) that honours the per-stage stall_x/bubble_x pair driven by the hazard detection unit.
- It is the receiving end of that control interface: it holds on stall, inserts a NOP on bubble, and loads otherwise.
- It also reports hazard activity through stall/bubble counters and a stuck-stall watchdog.
- Four instances (one per stage boundary) are instantiated in the core top.

Parameters:
- DATA_W, 64, width of packed datapath payload (pc, operands, immediate).
- CTRL_W, 16, width of packed control field (reg_write, mem_read, mem_write, branch, jal, jalr, ...).
- NOP_CTRL, 16'h0000, control value loaded on bubble; must decode to no architectural side effect.
- CNT_W, 16, width of stall and bubble event counters.
- STALL_TIMEOUT, 255, number of consecutive stall cycles that trips the watchdog; legal range 1..2^CNT_W-1.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset.
- stall, input, 1, hold current contents (stall_x from hazard unit).
- bubble, input, 1, replace contents with NOP (bubble_x from hazard unit).
- clr_cnt, input, 1, synchronous clear of counters and watchdog.
- in_valid, input, 1, upstream stage holds a real instruction.
- in_rd, input, 5, upstream destination register.
- in_ctrl, input, CTRL_W, upstream control field.
- in_data, input, DATA_W, upstream payload.
- out_valid, output, 1, registered valid.
- out_rd, output, 5, registered rd (feeds hazard unit rd_ex/rd_mem compare and forwarding).
- out_ctrl, output, CTRL_W, registered control.
- out_data, output, DATA_W, registered payload.
- out_state, output, 2, last update kind: LOADED=0, HELD=1, FLUSHED=2.
- stall_cnt, output, CNT_W, cycles with stall=1.
- bubble_cnt, output, CNT_W, effective bubble cycles.
- stall_timeout, output, 1, sticky watchdog flag.

Behaviour:
- Reset: rst is synchronous, active-high. On a rising edge with rst=1: out_valid=0, out_rd=0, out_ctrl=NOP_CTRL, out_data=0, out_state=FLUSHED, stall_cnt=0, bubble_cnt=0, stall_timeout=0, run counter=0. rst overrides every other input; reset in the middle of a stall discards the held instruction.
- Update priority per edge: rst > stall > bubble > load.
  - stall=1: all out_* hold, out_state=HELD. Stall beats a simultaneous bubble; the bubble is dropped and not counted.
  - bubble=1, stall=0: out_valid=0, out_rd=0 (guarantees the hazard/forwarding rd!=0 checks miss), out_ctrl=NOP_CTRL, out_data=0, out_state=FLUSHED.
  - otherwise: out_* load in_*, out_state=LOADED. When in_valid=0, out_rd and out_ctrl are still forced to 0/NOP_CTRL.
- Latency: one cycle input-to-output; no combinational in->out path.
- stall_cnt: +1 on each edge with stall=1 and rst=0; saturates at 2^CNT_W-1 with no wrap.
- bubble_cnt: +1 on each edge with bubble=1, stall=0, rst=0; saturates at 2^CNT_W-1.
- Watchdog: internal run counter (CNT_W bits) increments on each stall edge and clears on any non-stall edge.
  - When the run counter reaches STALL_TIMEOUT (i.e. after STALL_TIMEOUT consecutive stall edges), stall_timeout sets on that same edge.
  - stall_timeout is sticky until rst or clr_cnt.
- clr_cnt=1: stall_cnt, bubble_cnt, run counter and stall_timeout go to 0 on that edge. Clear wins over a same-cycle increment. It does not affect out_* or out_state.

Decomposition:
- Shared package pipe_ctrl_pkg: state encodings LOADED/HELD/FLUSHED, default NOP_CTRL constant, RD_ZERO constant, control-field bit positions.
- One sub-module: sat_counter (CNT_W, inc, clr, rst, saturating), instantiated for stall_cnt, bubble_cnt and the run counter. The run counter clears on ~stall | clr_cnt.

Test Plan:
- Load: rst 1 cycle, then in_valid=1, in_rd=5, in_data=64'h1234 with stall=bubble=0 -> next cycle out_valid=1, out_rd=5, out_data=64'h1234, out_state=LOADED.
- Stall hold: after load, stall=1 for 3 cycles while in_data changes to 64'hBEEF -> out_data stays 64'h1234, out_state=HELD, stall_cnt=3, bubble_cnt=0.
- Bubble: bubble=1 for 1 cycle with in_rd=7 -> out_valid=0, out_rd=0, out_ctrl=NOP_CTRL, out_data=0, out_state=FLUSHED, bubble_cnt=1.
- Stall+bubble same cycle: both=1 -> contents held, out_state=HELD, stall_cnt increments, bubble_cnt unchanged.
- Watchdog: STALL_TIMEOUT=4; stall for 3 cycles, drop 1 cycle, stall 4 cycles -> stall_timeout stays 0 through the first run and asserts on the 4th edge of the second run; it stays 1 after stall drops until clr_cnt=1, then 0 with both counters at 0.
- Saturation/reset: CNT_W=3, stall for 10 cycles -> stall_cnt saturates at 7; then rst mid-stall -> all outputs return to their reset values on the next edge.
